// File: rtl/reset_request_ctrl.sv
// System reset initiator: arbitrates software, watchdog and lock-loss causes,
// stretches an active-low request, then waits for PLL relock with bounded retries.
module reset_request_ctrl #(
  parameter int PULSE_CYCLES = 16,
  parameter int LOCK_STABLE  = 8,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int MAX_RETRY    = 3,
  parameter int WDT_LIMIT    = 1048576,
  parameter int CNT_W        = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_rst_req,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  input  logic       pll_locked,
  output logic       rst_req_n,
  output logic       busy,
  output logic [1:0] cause,
  output logic       timeout_err,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_LOCK, FAULT} state_t;
  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0, CAUSE_SW = 2'd1, CAUSE_WDT = 2'd2, CAUSE_LOCK = 2'd3
  } cause_t;

  localparam int              RW         = $clog2(MAX_RETRY + 2);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_N   = CNT_W'(LOCK_STABLE);
  localparam logic [CNT_W-1:0] TIMEOUT_N  = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] WDT_LAST   = CNT_W'(WDT_LIMIT - 1);
  localparam logic [RW-1:0]    RETRY_MAX  = RW'(MAX_RETRY);

  logic lk_meta, lk_s;

  // pll_locked is asynchronous to clk; only lk_s is used beyond this point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let both flops sample pre-edge values,
      // forming a real two-stage chain instead of collapsing into one flop.
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] stable_cnt, stable_nxt, stable_inc;
  logic [CNT_W-1:0] wdt_cnt, wdt_cnt_nxt;
  logic [RW-1:0]    retry, retry_nxt;
  logic             armed, armed_nxt;
  logic [1:0]       cause_nxt;
  logic             timeout_err_nxt, rst_req_n_nxt;
  logic             wdt_evt, lock_evt, enter_assert;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_nxt       = state;
    cnt_nxt         = cnt;
    stable_nxt      = stable_cnt;
    retry_nxt       = retry;
    armed_nxt       = armed;
    cause_nxt       = cause;
    timeout_err_nxt = timeout_err;
    rst_req_n_nxt   = rst_req_n;
    enter_assert    = 1'b0;
    cnt_inc         = cnt + CNT_W'(1);
    stable_inc      = lk_s ? stable_cnt + CNT_W'(1) : '0;

    wdt_evt  = (state == IDLE) && wdt_en && !wdt_kick && (wdt_cnt == WDT_LAST);
    lock_evt = (state == IDLE) && armed && !lk_s;

    if (!wdt_en || wdt_kick)  wdt_cnt_nxt = '0;
    else if (state == IDLE)   wdt_cnt_nxt = wdt_cnt + CNT_W'(1);
    else                      wdt_cnt_nxt = wdt_cnt;

    case (state)
      IDLE: begin
        if (lk_s) armed_nxt = 1'b1;
        if (sw_rst_req) begin
          enter_assert = 1'b1;
          cause_nxt    = CAUSE_SW;
        end else if (wdt_evt) begin
          enter_assert = 1'b1;
          cause_nxt    = CAUSE_WDT;
        end else if (lock_evt) begin
          enter_assert = 1'b1;
          cause_nxt    = CAUSE_LOCK;
        end
      end
      ASSERT: begin
        if (cnt == PULSE_LAST) begin
          state_nxt     = WAIT_LOCK;
          rst_req_n_nxt = 1'b1;
          cnt_nxt       = '0;
          stable_nxt    = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      WAIT_LOCK: begin
        cnt_nxt    = cnt_inc;
        stable_nxt = stable_inc;
        // Relock is checked first so it wins over a coincident timeout.
        if (stable_inc == STABLE_N) begin
          state_nxt  = IDLE;
          retry_nxt  = '0;
          armed_nxt  = 1'b1;
          cnt_nxt    = '0;
          stable_nxt = '0;
        end else if (cnt_inc == TIMEOUT_N) begin
          timeout_err_nxt = 1'b1;
          if (retry < RETRY_MAX) begin
            enter_assert = 1'b1;
            retry_nxt    = retry + RW'(1);
          end else begin
            state_nxt = FAULT;
          end
        end
      end
      FAULT: begin
        if (sw_rst_req) begin
          enter_assert = 1'b1;
          cause_nxt    = CAUSE_SW;
          retry_nxt    = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (enter_assert) begin
      state_nxt     = ASSERT;
      rst_req_n_nxt = 1'b0;
      cnt_nxt       = '0;
      wdt_cnt_nxt   = '0;
      armed_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      stable_cnt  <= '0;
      wdt_cnt     <= '0;
      retry       <= '0;
      armed       <= 1'b0;
      cause       <= CAUSE_NONE;
      timeout_err <= 1'b0;
      rst_req_n   <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      stable_cnt  <= stable_nxt;
      wdt_cnt     <= wdt_cnt_nxt;
      retry       <= retry_nxt;
      armed       <= armed_nxt;
      cause       <= cause_nxt;
      timeout_err <= timeout_err_nxt;
      rst_req_n   <= rst_req_n_nxt;
    end
  end

  assign busy  = (state != IDLE);
  assign fault = (state == FAULT);

endmodule

// File: tb/tb_reset_request_ctrl.sv
// Bench for reset_request_ctrl: directed scenarios plus random traffic, checked
// every cycle against a phase/countdown model of the reset-request behaviour.
module tb_reset_request_ctrl;

  localparam int P_PULSE   = 16;
  localparam int P_STABLE  = 8;
  localparam int P_TIMEOUT = 64;
  localparam int P_RETRY   = 3;
  localparam int P_WDT     = 1000;

  logic       clk = 1'b0;
  logic       rst_n, sw_rst_req, wdt_en, wdt_kick, pll_locked;
  logic       rst_req_n, busy, timeout_err, fault;
  logic [1:0] cause;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reset_request_ctrl #(
    .PULSE_CYCLES(P_PULSE), .LOCK_STABLE(P_STABLE), .LOCK_TIMEOUT(P_TIMEOUT),
    .MAX_RETRY(P_RETRY), .WDT_LIMIT(P_WDT), .CNT_W(21)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .wdt_en(wdt_en),
    .wdt_kick(wdt_kick), .pll_locked(pll_locked), .rst_req_n(rst_req_n),
    .busy(busy), .cause(cause), .timeout_err(timeout_err), .fault(fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus elapsed-cycle counters, advanced once per edge.
  localparam int M_IDLE = 0, M_PULSE = 1, M_WAIT = 2, M_FAULT = 3;
  int m_phase, m_elapsed, m_wait_age, m_lock_run, m_attempt, m_dog, m_cause;
  bit m_armed, m_terr, m_h1, m_h2;

  task automatic m_start_pulse();
    m_phase   = M_PULSE;
    m_elapsed = 0;
    m_attempt = m_attempt + 1;
    m_dog     = 0;
    m_armed   = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = M_IDLE; m_elapsed = 0; m_wait_age = 0; m_lock_run = 0;
      m_attempt = 0; m_dog = 0; m_cause = 0; m_armed = 0; m_terr = 0;
      m_h1 = 0; m_h2 = 0;
    end else begin
      bit lk;
      int req;
      lk = m_h2;
      m_h2 = m_h1;
      m_h1 = pll_locked;
      req = 0;
      if (m_phase == M_IDLE) begin
        if (sw_rst_req) req = 1;
        else if (wdt_en && !wdt_kick && m_dog == P_WDT - 1) req = 2;
        else if (m_armed && !lk) req = 3;
      end
      if (!wdt_en || wdt_kick) m_dog = 0;
      else if (m_phase == M_IDLE) m_dog = m_dog + 1;
      case (m_phase)
        M_IDLE: begin
          if (lk) m_armed = 1;
          if (req != 0) begin
            m_cause = req;
            m_start_pulse();
          end
        end
        M_PULSE: begin
          m_elapsed = m_elapsed + 1;
          if (m_elapsed == P_PULSE) begin
            m_phase = M_WAIT; m_wait_age = 0; m_lock_run = 0;
          end
        end
        M_WAIT: begin
          m_wait_age = m_wait_age + 1;
          m_lock_run = lk ? m_lock_run + 1 : 0;
          if (m_lock_run == P_STABLE) begin
            m_phase = M_IDLE; m_attempt = 0; m_armed = 1;
          end else if (m_wait_age == P_TIMEOUT) begin
            m_terr = 1;
            if (m_attempt <= P_RETRY) m_start_pulse();
            else m_phase = M_FAULT;
          end
        end
        default: begin
          if (sw_rst_req) begin
            m_cause = 1; m_attempt = 0;
            m_start_pulse();
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [5:0] exp;
    exp = {m_phase != M_PULSE, m_phase != M_IDLE, 2'(m_cause), m_terr, m_phase == M_FAULT};
    check("cycle_outputs", {rst_req_n, busy, cause, timeout_err, fault}, exp);
  end

  // Pulse-width monitor used by the literal checks.
  int low_len = 0, pulses = 0, last_width = 0;
  always @(negedge clk) begin
    if (!rst_n) low_len = 0;
    else if (!rst_req_n) low_len++;
    else if (low_len != 0) begin
      pulses++;
      last_width = low_len;
      low_len = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sw_pulse();
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
  endtask

  task automatic wait_busy(input logic level, input int max, input string name, output int n);
    n = 0;
    while (busy !== level && n < max) begin
      tick(1);
      n++;
    end
    check(name, busy, level);
  endtask

  initial begin
    int n, base;
    rst_n = 1'b0; sw_rst_req = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0; pll_locked = 1'b0;
    #12;
    check("reset_outputs", {rst_req_n, busy, cause, timeout_err, fault}, 6'b100000);
    #11 rst_n = 1'b1;
    tick(5);

    // Software request, PLL relocks after 30 cycles.
    base = pulses;
    sw_pulse();
    check("sw_req_low", {rst_req_n, busy, cause}, 4'b0101);
    tick(29);
    pll_locked = 1'b1;
    wait_busy(1'b0, 100, "sw_return_idle", n);
    check("sw_relock_latency", n, 10);
    check("sw_width", last_width, P_PULSE);
    check("sw_pulse_count", pulses - base, 1);
    check("sw_no_timeout", timeout_err, 1'b0);

    // Watchdog expiry with no kick.
    tick(3);
    wdt_en = 1'b1;
    wait_busy(1'b1, 1200, "wdt_fires", n);
    check("wdt_latency", n, P_WDT);
    check("wdt_cause", cause, 2'd2);
    wdt_en = 1'b0;
    wait_busy(1'b0, 200, "wdt_return_idle", n);

    // Regular kicks keep the watchdog quiet.
    base = pulses;
    wdt_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      wdt_kick = (i % 500 == 0);
      tick(1);
    end
    wdt_kick = 1'b0; wdt_en = 1'b0;
    check("kick_no_request", pulses - base, 0);
    check("kick_idle", busy, 1'b0);

    // One-cycle lock drop while armed.
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    n = 1;
    while (!busy && n < 20) begin
      tick(1);
      n++;
    end
    check("lockloss_latency", n, 3);
    check("lockloss_cause", cause, 2'd3);
    wait_busy(1'b0, 200, "lockloss_return_idle", n);

    // No relock at all: four attempts then FAULT.
    base = pulses;
    pll_locked = 1'b0;
    sw_pulse();
    n = 0;
    while (!fault && n < 1000) begin
      tick(1);
      n++;
    end
    check("fault_set", {fault, timeout_err, busy, rst_req_n}, 4'b1111);
    check("fault_pulse_count", pulses - base, 1 + P_RETRY);
    check("fault_last_width", last_width, P_PULSE);
    sw_pulse();
    check("fault_sw_restart", {fault, busy, rst_req_n, cause}, 5'b01001);
    pll_locked = 1'b1;
    wait_busy(1'b0, 200, "fault_recover_idle", n);

    // Software, watchdog expiry and lock loss in the same cycle.
    tick(3);
    base = pulses;
    wdt_en = 1'b1;
    tick(997);
    pll_locked = 1'b0;
    tick(2);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0; pll_locked = 1'b1; wdt_en = 1'b0;
    check("simul_cause", {busy, cause}, 3'b101);
    wait_busy(1'b0, 200, "simul_return_idle", n);
    check("simul_single_pulse", pulses - base, 1);

    // Software request while the pulse is running is dropped.
    base = pulses;
    sw_pulse();
    tick(5);
    sw_pulse();
    wait_busy(1'b0, 200, "sw_in_assert_idle", n);
    check("sw_in_assert_width", last_width, P_PULSE);
    check("sw_in_assert_count", pulses - base, 1);

    // Asynchronous reset in the middle of the pulse.
    sw_pulse();
    tick(5);
    #2 rst_n = 1'b0;
    #1 check("midassert_reset", {rst_req_n, busy, cause, timeout_err, fault}, 6'b100000);
    pll_locked = 1'b0;
    #12 rst_n = 1'b1;
    tick(50);
    check("no_lockloss_unarmed", {busy, cause}, 3'b000);

    // Random traffic, checked by the per-cycle compare.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) pll_locked = ~pll_locked;
      if ($urandom_range(0, 299) == 0) wdt_en = ~wdt_en;
      sw_rst_req = ($urandom_range(0, 99) == 0);
      wdt_kick   = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    sw_rst_req = 1'b0; wdt_kick = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reset_request_ctrl.md
Name: reset_request_ctrl

Overview:
Initiator side of the system reset path. Collects reset causes and drives a stretched active-low reset request into the system clock/reset block's hard-reset input:
- software request from NIOS
- watchdog expiry
- loss of PLL lock

After the request, it waits for PLL lock to return and be stable, retries on timeout, and reports the cause and fault status to NIOS.

Parameters:
PULSE_CYCLES, 16, cycles rst_req_n is held low per request (>=2)
LOCK_STABLE, 8, consecutive synchronized-locked cycles required to declare relock
LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK before a retry
MAX_RETRY, 3, retries after the first attempt before entering FAULT
WDT_LIMIT, 1048576, watchdog count at which expiry fires
CNT_W, 21, width of the shared counters (must hold WDT_LIMIT and LOCK_TIMEOUT)

Ports:
clk  input  1  free-running reference clock (sys_clk domain, not PLL output)
rst_n  input  1  asynchronous active-low reset
sw_rst_req  input  1  single-cycle software reset request
wdt_en  input  1  watchdog enable (level)
wdt_kick  input  1  single-cycle watchdog service pulse
pll_locked  input  1  PLL lock, asynchronous to clk
rst_req_n  output  1  registered active-low reset request to hard-reset input
busy  output  1  high whenever state != IDLE
cause  output  2  last request cause: 0 none, 1 software, 2 watchdog, 3 lock loss
timeout_err  output  1  sticky: at least one WAIT_LOCK timeout occurred
fault  output  1  high in FAULT state

Behaviour:
- Reset (rst_n low, async): state IDLE, rst_req_n=1, busy=0, cause=0, timeout_err=0, fault=0, all counters 0, armed=0, sync flops 0.
- Lock synchronizer: pll_locked passes through a 2-flop synchronizer to give lk_s (2-cycle latency). All logic uses lk_s only.
- armed flag: set the first cycle lk_s=1 in IDLE; cleared on entry to ASSERT.
- Lock-loss event: IDLE && armed && lk_s==0.
- Watchdog: counts +1 per cycle while IDLE && wdt_en.
  - Count cleared by wdt_kick, by wdt_en=0, and on entry to ASSERT.
  - Expiry event when count == WDT_LIMIT-1 and no kick that cycle.
  - Kick in the expiry cycle wins (no expiry).
- Request arbitration in IDLE, same cycle, priority sw_rst_req > watchdog > lock loss. The winner's code is loaded into cause.
- Requests arriving while not IDLE are dropped (no queuing). Exception: sw_rst_req in FAULT (see below).
- IDLE -> ASSERT on any request. rst_req_n goes low the cycle after the request cycle.
- ASSERT:
  - rst_req_n=0 for exactly PULSE_CYCLES cycles.
  - Retry counter unchanged.
  - Then -> WAIT_LOCK with rst_req_n=1 and counters cleared.
- WAIT_LOCK:
  - Timeout counter increments every cycle.
  - Stable counter increments while lk_s=1 and clears when lk_s=0.
  - Stable counter reaching LOCK_STABLE -> IDLE, retry counter cleared, armed set.
  - Timeout counter reaching LOCK_TIMEOUT (with stable not reached in that cycle) -> timeout_err set.
    - If retries < MAX_RETRY: -> ASSERT, retries+1.
    - Else -> FAULT.
  - Relock and timeout in the same cycle: relock wins.
- FAULT:
  - fault=1, busy=1, rst_req_n=1.
  - Watchdog and lock loss are ignored.
  - sw_rst_req -> ASSERT with cause=1, retries cleared, fault cleared.
- timeout_err is sticky and cleared only by rst_n.
- cause holds its value until the next accepted request.
- Asynchronous rst_n mid-ASSERT: rst_req_n returns to 1 immediately (async). No request is remembered.
- Glitch-free output: rst_req_n is driven directly from a flop.

Test Plan:
- Software request: PULSE_CYCLES=16, pll_locked low for 30 cycles then high. Pulse sw_rst_req at cycle 100 -> rst_req_n low cycles 101..116, busy=1, cause=1. Return to IDLE 2+8 cycles after pll_locked rises. timeout_err=0.
- Watchdog, WDT_LIMIT=1000:
  - wdt_en=1, no kick -> request fires at count 999, cause=2.
  - Kick every 500 cycles -> no request in 10000 cycles.
- Lock loss after armed: drop pll_locked for 1 cycle -> request ~3 cycles later, cause=3.
  - Lock loss immediately after rst_n release with pll_locked never high -> no request.
- Timeout/fault: LOCK_TIMEOUT=64, MAX_RETRY=3, pll_locked held 0 after sw request -> 4 low pulses on rst_req_n, then fault=1, timeout_err=1.
  - Later sw_rst_req -> ASSERT, fault=0.
- Simultaneous: sw_rst_req, wdt expiry and lock loss in the same IDLE cycle -> cause=1, single pulse.
  - sw_rst_req during ASSERT -> ignored, pulse length still 16.
  - Assert rst_n low mid-ASSERT -> rst_req_n=1 asynchronously, all outputs at reset values.
